// File: rtl/jtag_cmd_decoder_if.sv
// rtl/jtag_cmd_decoder_if.sv - JTAG command word in, decoded DRFM parameters out
`timescale 1ns/1ps
interface jtag_cmd_decoder_if #(
   parameter int W_FIELD = 10
);
   logic               udr;
   logic [31:0]        dr_word;
   logic               tck_busy;
   logic [7:0]         drop_cnt;
   logic [W_FIELD-1:0] delay_val;
   logic [W_FIELD-1:0] doppler_val;
   logic [W_FIELD-1:0] scale_val;
   logic               load_pulse;
   logic               cmd_valid;
   logic [3:0]         cmd_state;
   logic [W_FIELD-1:0] led;

   modport master (
      output udr, dr_word,
      input  tck_busy, drop_cnt, delay_val, doppler_val, scale_val,
             load_pulse, cmd_valid, cmd_state, led
   );

   modport slave (
      input  udr, dr_word,
      output tck_busy, drop_cnt, delay_val, doppler_val, scale_val,
             load_pulse, cmd_valid, cmd_state, led
   );
endinterface

// File: rtl/jtag_cmd_decoder.sv
// rtl/jtag_cmd_decoder.sv - TCK-to-clk toggle handshake and command word sequencer
`timescale 1ns/1ps
module jtag_cmd_decoder #(
   parameter int W_FIELD     = 10,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              aclr,
   input  logic              tck,
   jtag_cmd_decoder_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DECODE  = 2'd2,
      ACK     = 2'd3
   } state_t;

   // TCK domain
   logic                   udr_d;
   logic                   req_t;
   logic [31:0]            hold_q;
   logic [7:0]             drop_q;
   logic [SYNC_STAGES-1:0] ack_sync_q;
   logic                   ack_t;
   logic                   busy;
   logic                   udr_rise;

   assign udr_rise = bus.udr & ~udr_d;
   assign busy     = req_t ^ ack_sync_q[SYNC_STAGES-1];

   always_ff @(posedge tck or posedge aclr) begin
      if (aclr) begin
         udr_d      <= 1'b0;
         req_t      <= 1'b0;
         hold_q     <= '0;
         drop_q     <= '0;
         ack_sync_q <= '0;
      end else begin
         udr_d      <= bus.udr;
         ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_t};
         // hold_q only moves while idle, so the clk side may sample it without synchronising
         if (udr_rise && !busy) begin
            hold_q <= bus.dr_word;
            req_t  <= ~req_t;
         end else if (udr_rise && drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'd1;
         end
      end
   end

   // clk domain
   logic [SYNC_STAGES-1:0] req_sync_q;
   logic                   edge_q;
   logic                   new_req;
   state_t                 state_q, state_d;
   logic [31:0]            word_q;
   logic [W_FIELD-1:0]     delay_q, doppler_q, scale_q, led_q;
   logic [3:0]             cmd_state_q;
   logic                   cmd_valid_q, load_q;

   assign new_req = req_sync_q[SYNC_STAGES-1] ^ edge_q;

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (new_req) state_d = CAPTURE;
         CAPTURE: state_d = DECODE;
         DECODE:  state_d = ACK;
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         req_sync_q  <= '0;
         edge_q      <= 1'b0;
         ack_t       <= 1'b0;
         word_q      <= '0;
         delay_q     <= '0;
         doppler_q   <= '0;
         scale_q     <= '0;
         led_q       <= '0;
         cmd_state_q <= 4'b0000;
         cmd_valid_q <= 1'b0;
         load_q      <= 1'b0;
      end else begin
         req_sync_q  <= {req_sync_q[SYNC_STAGES-2:0], req_t};
         edge_q      <= req_sync_q[SYNC_STAGES-1];
         cmd_valid_q <= (state_q == DECODE);
         load_q      <= 1'b0;
         if (state_q == CAPTURE) word_q <= hold_q;
         if (state_q == ACK)     ack_t  <= ~ack_t;
         if (state_q == DECODE) begin
            // lowest flag bit wins
            if (word_q[W_FIELD]) begin
               delay_q     <= word_q[W_FIELD-1:0];
               led_q       <= word_q[W_FIELD-1:0];
               cmd_state_q <= 4'b0001;
            end else if (word_q[2*W_FIELD]) begin
               doppler_q   <= word_q[2*W_FIELD-1:W_FIELD];
               led_q       <= word_q[2*W_FIELD-1:W_FIELD];
               cmd_state_q <= 4'b1000;
            end else if (word_q[3*W_FIELD]) begin
               scale_q     <= word_q[3*W_FIELD-1:2*W_FIELD];
               led_q       <= word_q[3*W_FIELD-1:2*W_FIELD];
               cmd_state_q <= 4'b0010;
            end else if (word_q[31]) begin
               load_q      <= 1'b1;
               cmd_state_q <= 4'b0100;
            end else begin
               cmd_state_q <= 4'b0000;
            end
         end
      end
   end

   assign bus.tck_busy    = busy;
   assign bus.drop_cnt    = drop_q;
   assign bus.delay_val   = delay_q;
   assign bus.doppler_val = doppler_q;
   assign bus.scale_val   = scale_q;
   assign bus.led         = led_q;
   assign bus.cmd_state   = cmd_state_q;
   assign bus.cmd_valid   = cmd_valid_q;
   assign bus.load_pulse  = load_q;
endmodule

// File: tb/tb_jtag_cmd_decoder.sv
// tb/tb_jtag_cmd_decoder.sv - bench for jtag_cmd_decoder
`timescale 1ns/1ps
module tb_jtag_cmd_decoder;
   typedef struct {
      logic [31:0] word;
      logic [3:0]  st;
      logic [9:0]  dl;
      logic [9:0]  dp;
      logic [9:0]  sc;
      logic [9:0]  led;
      logic        ld;
   } vec_t;

   logic clk, tck, aclr;
   int   clk_half;
   bit   clk_run;
   int   checks, errors;
   int   valid_cnt, load_cnt, exp_valid, exp_loads;
   vec_t sb[$];
   vec_t tbl[9];

   jtag_cmd_decoder_if #(.W_FIELD(10)) ifc ();

   jtag_cmd_decoder #(.W_FIELD(10), .SYNC_STAGES(2)) dut (
      .clk  (clk),
      .aclr (aclr),
      .tck  (tck),
      .bus  (ifc.slave)
   );

   initial clk = 1'b0;
   always begin
      #(clk_half);
      if (clk_run) clk = ~clk;
   end

   initial tck = 1'b0;
   always #25 tck = ~tck;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      vec_t e;
      if (!aclr) begin
         if (ifc.load_pulse) load_cnt++;
         if (ifc.cmd_valid) begin
            valid_cnt++;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_cmd_valid: got cmd_state %b with nothing expected", ifc.cmd_state);
            end else begin
               e = sb.pop_front();
               check("cmd_state",   32'(ifc.cmd_state),   32'(e.st));
               check("delay_val",   32'(ifc.delay_val),   32'(e.dl));
               check("doppler_val", 32'(ifc.doppler_val), 32'(e.dp));
               check("scale_val",   32'(ifc.scale_val),   32'(e.sc));
               check("led",         32'(ifc.led),         32'(e.led));
               check("load_pulse",  32'(ifc.load_pulse),  32'(e.ld));
            end
         end
      end
   end

   task automatic expect_word(input vec_t v);
      sb.push_back(v);
      exp_valid++;
      if (v.ld) exp_loads++;
   endtask

   task automatic send_word(input logic [31:0] w);
      @(negedge tck);
      ifc.dr_word = w;
      ifc.udr     = 1'b1;
      @(negedge tck);
      check("busy_set", 32'(ifc.tck_busy), 32'd1);
      ifc.udr = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      while (ifc.tck_busy && k < budget) begin
         @(negedge tck);
         k++;
      end
      checks++;
      if (ifc.tck_busy) begin
         errors++;
         $display("FAIL wait_idle: tck_busy still 1 after %0d tck, required 0", budget);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic drain_checks(input string tag);
      check({tag, "_sb_empty"},  32'(sb.size()), 32'd0);
      check({tag, "_valid_cnt"}, 32'(valid_cnt),  32'(exp_valid));
      check({tag, "_load_cnt"},  32'(load_cnt),   32'(exp_loads));
   endtask

   initial begin
      int k;
      int valid_snap;
      checks = 0; errors = 0;
      valid_cnt = 0; load_cnt = 0; exp_valid = 0; exp_loads = 0;
      clk_half = 5; clk_run = 1'b1;
      aclr = 1'b1; ifc.udr = 1'b0; ifc.dr_word = '0;

      //            word           st       dl      dp      sc      led     ld
      tbl[0] = '{32'h0000_0555, 4'b0001, 10'h155, 10'h000, 10'h000, 10'h155, 1'b0};
      tbl[1] = '{32'h4010_0400, 4'b0001, 10'h000, 10'h000, 10'h000, 10'h000, 1'b0};
      tbl[2] = '{32'h0015_5000, 4'b1000, 10'h000, 10'h154, 10'h000, 10'h154, 1'b0};
      tbl[3] = '{32'h7FE0_0000, 4'b0010, 10'h000, 10'h154, 10'h3FE, 10'h3FE, 1'b0};
      tbl[4] = '{32'h8000_0000, 4'b0100, 10'h000, 10'h154, 10'h3FE, 10'h3FE, 1'b1};
      tbl[5] = '{32'h0000_0000, 4'b0000, 10'h000, 10'h154, 10'h3FE, 10'h3FE, 1'b0};
      tbl[6] = '{32'h4FF0_0000, 4'b1000, 10'h000, 10'h000, 10'h3FE, 10'h000, 1'b0};
      tbl[7] = '{32'h8000_07FF, 4'b0001, 10'h3FF, 10'h000, 10'h3FE, 10'h3FF, 1'b0};
      tbl[8] = '{32'hC000_0000, 4'b0010, 10'h3FF, 10'h000, 10'h000, 10'h000, 1'b0};

      repeat (4) @(negedge clk);
      check("rst_cmd_state", 32'(ifc.cmd_state),   32'd0);
      check("rst_delay",     32'(ifc.delay_val),   32'd0);
      check("rst_doppler",   32'(ifc.doppler_val), 32'd0);
      check("rst_scale",     32'(ifc.scale_val),   32'd0);
      check("rst_led",       32'(ifc.led),         32'd0);
      check("rst_cmd_valid", 32'(ifc.cmd_valid),   32'd0);
      check("rst_load",      32'(ifc.load_pulse),  32'd0);
      check("rst_busy",      32'(ifc.tck_busy),    32'd0);
      check("rst_drop",      32'(ifc.drop_cnt),    32'd0);
      aclr = 1'b0;
      repeat (4) @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         expect_word(tbl[i]);
         send_word(tbl[i].word);
         wait_idle(200);
         drain_checks($sformatf("vec%0d", i));
      end

      // overrun with a slow system clock: second edge lands while busy
      clk_half = 250;
      @(negedge clk);
      expect_word('{32'h0000_04AA, 4'b0001, 10'h0AA, 10'h000, 10'h000, 10'h0AA, 1'b0});
      send_word(32'h0000_04AA);
      @(negedge tck);
      ifc.dr_word = 32'h0000_0433;
      ifc.udr     = 1'b1;
      @(negedge tck);
      ifc.udr = 1'b0;
      check("ovr_drop_cnt", 32'(ifc.drop_cnt), 32'd1);
      wait_idle(1000);
      clk_half = 5;
      repeat (4) @(negedge clk);
      drain_checks("ovr");
      check("ovr_delay", 32'(ifc.delay_val), 32'h0AA);

      // saturation: system clock halted so the handshake never completes
      clk_run = 1'b0;
      expect_word('{32'h0000_0555, 4'b0001, 10'h155, 10'h000, 10'h000, 10'h155, 1'b0});
      send_word(32'h0000_0555);
      for (int i = 0; i < 300; i++) begin
         @(negedge tck);
         ifc.dr_word = 32'hFFFF_FFFF;
         ifc.udr     = 1'b1;
         @(negedge tck);
         ifc.udr = 1'b0;
         if (i == 252) check("sat_drop_254", 32'(ifc.drop_cnt), 32'd254);
      end
      check("sat_drop_255", 32'(ifc.drop_cnt), 32'd255);
      check("sat_no_valid", 32'(valid_cnt), 32'(exp_valid - 1));
      clk_run = 1'b1;
      wait_idle(200);
      drain_checks("sat");

      // reset during CAPTURE
      @(negedge tck);
      ifc.dr_word = 32'h0015_5000;
      ifc.udr     = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (dut.state_q != 2'd1 && k < 100);
      checks++;
      if (dut.state_q != 2'd1) begin
         errors++;
         $display("FAIL rst_capture_wait: CAPTURE not reached in %0d clk", k);
      end
      aclr = 1'b1;
      ifc.udr = 1'b0;
      repeat (2) @(negedge clk);
      check("mrst_cmd_state", 32'(ifc.cmd_state),   32'd0);
      check("mrst_delay",     32'(ifc.delay_val),   32'd0);
      check("mrst_doppler",   32'(ifc.doppler_val), 32'd0);
      check("mrst_scale",     32'(ifc.scale_val),   32'd0);
      check("mrst_led",       32'(ifc.led),         32'd0);
      check("mrst_busy",      32'(ifc.tck_busy),    32'd0);
      check("mrst_drop",      32'(ifc.drop_cnt),    32'd0);
      valid_snap = valid_cnt;
      aclr = 1'b0;
      repeat (20) @(negedge clk);
      check("mrst_no_valid", 32'(valid_cnt), 32'(valid_snap));
      check("mrst_cmd_valid", 32'(ifc.cmd_valid), 32'd0);

      expect_word('{32'h7FE0_0000, 4'b0010, 10'h000, 10'h000, 10'h3FE, 10'h3FE, 1'b0});
      send_word(32'h7FE0_0000);
      wait_idle(200);
      drain_checks("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
